// File: rtl/imem_responder.sv
// imem_responder: instruction memory with a fixed-latency request/response
// handshake. It has a program-load write port that is active in every state,
// plus flush and asynchronous reset, both of which cancel an outstanding fetch.
module imem_responder #(
   parameter int unsigned DEPTH   = 1024,  // words, power of two, >= 2
   parameter int unsigned LATENCY = 2      // 1..15 edges from accept to response
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic [31:0] rsp_addr,
   output logic        rsp_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic [3:0]  w_next_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_rsp_instr;
   logic [31:0] r_rsp_addr;
   logic        r_rsp_err;
   logic [31:0] r_mem [DEPTH];

   logic        w_req_ready;
   logic        w_accept;
   logic        w_capture;
   logic        w_req_ok;
   logic        w_ld_ok;

   // Both addresses must be word aligned and inside the array. The range
   // check runs on the full address, so an out-of-range access never wraps
   // onto a low word.
   assign w_req_ok = (r_addr[1:0] == 2'b00) && ({2'b00, r_addr[31:2]} < 32'(DEPTH));
   assign w_ld_ok  = (ld_addr[1:0] == 2'b00) && ({2'b00, ld_addr[31:2]} < 32'(DEPTH));

   assign w_req_ready = !reset && (r_state == S_IDLE) && !flush;
   assign w_accept    = req_valid && w_req_ready;

   assign req_ready = w_req_ready;
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_instr = r_rsp_instr;
   assign rsp_addr  = r_rsp_addr;
   assign rsp_err   = r_rsp_err;

   // Program-load write port. It has no reset, so memory contents survive
   // a reset.
   always_ff @(posedge clk) begin
      if (ld_en && w_ld_ok) begin
         r_mem[ld_addr[AW+1:2]] <= ld_data;
      end
   end

   // State, latency counter and request address register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_accept) begin
            r_addr <= req_addr;
         end
      end
   end

   // Next-state logic. Flush wins over both the counter expiry and rsp_ready.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next_state = S_WAIT;
               w_next_cnt   = 4'(LATENCY - 1);
            end
         end
         S_WAIT: begin
            if (flush) begin
               w_next_state = S_IDLE;
               w_next_cnt   = '0;
            end else if (r_cnt == 4'd0) begin
               w_next_state = S_RESP;
               w_capture    = 1'b1;
            end else begin
               w_next_cnt = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            if (flush || rsp_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // Response capture. The memory read sees the pre-edge contents, so a load
   // that lands on the capture edge itself returns the old word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_instr <= '0;
         r_rsp_addr  <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_capture) begin
         r_rsp_addr <= r_addr;
         r_rsp_err  <= !w_req_ok;
         r_rsp_instr <= w_req_ok ? r_mem[r_addr[AW+1:2]] : 32'h0;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder (DEPTH 1024, LATENCY 2).
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        flush = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_err;
   logic        ld_en = 1'b0;
   logic [31:0] ld_addr = '0;
   logic [31:0] ld_data = '0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   imem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Present a request and consume the accepting edge.
   task automatic issue(input string tag, input logic [31:0] a);
      req_addr = a; req_valid = 1'b1;
      #1;
      chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic expect_rsp(input string tag, input logic [31:0] a,
                             input logic [31:0] instr, input logic err);
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".rsp_instr"}, rsp_instr, instr);
      chk({tag, ".rsp_addr"},  rsp_addr, a);
      chk({tag, ".rsp_err"},   32'(rsp_err), 32'(err));
   endtask

   task automatic drain(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      chk({tag, ".drain_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".drain_ready"}, 32'(req_ready), 32'd1);
   endtask

   // Full fetch with the latency check: rsp_valid low after edges N and N+1,
   // high after edge N+2.
   task automatic fetch(input string tag, input logic [31:0] a,
                        input logic [31:0] instr, input logic err);
      issue(tag, a);
      chk({tag, ".lat0"}, 32'(rsp_valid), 32'd0);
      tick();
      chk({tag, ".lat1"}, 32'(rsp_valid), 32'd0);
      tick();
      expect_rsp(tag, a, instr, err);
      drain(tag);
   endtask

   initial begin
      // Asynchronous reset before any clock edge.
      #1 reset = 1'b1;
      #1;
      chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst.req_ready", 32'(req_ready), 32'd0);
      chk("rst.rsp_instr", rsp_instr, 32'h0);
      chk("rst.rsp_addr",  rsp_addr, 32'h0);
      chk("rst.rsp_err",   32'(rsp_err), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst.release_ready", 32'(req_ready), 32'd1);

      load(32'h10, 32'hE3A00001);
      load(32'h14, 32'h12345678);
      load(32'h20, 32'hAAAA0000);
      load(32'h00, 32'h11111111);

      // Basic fetch with a stalled consumer.
      issue("basic", 32'h10);
      chk("basic.lat0", 32'(rsp_valid), 32'd0);
      tick();
      chk("basic.lat1", 32'(rsp_valid), 32'd0);
      tick();
      expect_rsp("basic", 32'h10, 32'hE3A00001, 1'b0);
      req_valid = 1'b1; req_addr = 32'h14;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_rsp("hold", 32'h10, 32'hE3A00001, 1'b0);
         chk("hold.req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      drain("hold");

      // Flush one cycle after acceptance cancels the fetch.
      issue("flush", 32'h10);
      flush = 1'b1;
      #1;
      chk("flush.req_ready", 32'(req_ready), 32'd0);
      tick();
      flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("flush.no_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end
      fetch("after_flush", 32'h14, 32'h12345678, 1'b0);

      // Flush in IDLE refuses the concurrent request.
      req_valid = 1'b1; req_addr = 32'h10; flush = 1'b1;
      #1;
      chk("idleflush.req_ready", 32'(req_ready), 32'd0);
      tick();
      req_valid = 1'b0; flush = 1'b0;
      #1;
      chk("idleflush.still_idle", 32'(req_ready), 32'd1);
      tick();
      tick();
      chk("idleflush.no_rsp", 32'(rsp_valid), 32'd0);

      // Flush in RESP with rsp_ready low drops the response.
      issue("respflush", 32'h14);
      tick();
      tick();
      chk("respflush.valid", 32'(rsp_valid), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("respflush.dropped", 32'(rsp_valid), 32'd0);

      // Error cases and ignored loads.
      fetch("misal", 32'h12, 32'h0, 1'b1);
      fetch("oor", 32'h1000, 32'h0, 1'b1);
      load(32'h1000, 32'hDEADBEEF);
      load(32'h11, 32'h00000BAD);
      fetch("noalias", 32'h0, 32'h11111111, 1'b0);
      fetch("nomisal_ld", 32'h10, 32'hE3A00001, 1'b0);

      // Load during WAIT, before the capture edge: new data is returned.
      issue("ldwait", 32'h20);
      ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'hBBBB0001;
      tick();
      ld_en = 1'b0;
      tick();
      expect_rsp("ldwait", 32'h20, 32'hBBBB0001, 1'b0);
      drain("ldwait");

      // Load on the capture edge itself: old data is returned.
      issue("ldcap", 32'h20);
      tick();
      ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'hCCCC0002;
      tick();
      ld_en = 1'b0;
      expect_rsp("ldcap", 32'h20, 32'hBBBB0001, 1'b0);
      drain("ldcap");
      fetch("ldcap_after", 32'h20, 32'hCCCC0002, 1'b0);

      // Asynchronous reset between edges while in RESP.
      issue("rstresp", 32'h10);
      tick();
      tick();
      chk("rstresp.valid", 32'(rsp_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rstresp.valid_drop", 32'(rsp_valid), 32'd0);
      chk("rstresp.instr_clr", rsp_instr, 32'h0);
      chk("rstresp.addr_clr",  rsp_addr, 32'h0);
      chk("rstresp.ready_low", 32'(req_ready), 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("rstresp.ready_high", 32'(req_ready), 32'd1);
      chk("rstresp.no_rsp", 32'(rsp_valid), 32'd0);
      fetch("refetch", 32'h10, 32'hE3A00001, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
